// File: rtl/irq_prio_capture.sv
// Rising-edge request capture with sticky pending bits, mask, and a registered highest-index code with valid/ack.
// Optional IRQ_PRIO_OVERFLOW_EN adds a sticky per-line overflow output for edges merged into an already pending bit.
module irq_prio_capture #(
    parameter int WIDTH  = 4,
    parameter int CODE_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  req,
    input  logic              mask_we,
    input  logic [WIDTH-1:0]  mask_wdata,
    input  logic              ack,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    output logic [WIDTH-1:0]  pending,
`ifdef IRQ_PRIO_OVERFLOW_EN
    output logic [WIDTH-1:0]  overflow,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        CLEAR   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    req_q;
    logic [WIDTH-1:0]    pending_q, pending_d;
    logic [WIDTH-1:0]    mask_q, mask_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                valid_q, valid_d;
    logic [WIDTH-1:0]    rise;
    logic [WIDTH-1:0]    clr;
    logic [WIDTH-1:0]    eligible;

    function automatic logic [CODE_W-1:0] highest(input logic [WIDTH-1:0] v);
        logic [CODE_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) idx = CODE_W'(i);
        end
        return idx;
    endfunction

    assign rise     = req & ~req_q;
    assign eligible = pending_q & mask_q;
    assign mask_d   = mask_we ? mask_wdata : mask_q;

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        valid_d   = valid_q;
        clr       = '0;
        case (state_q)
            IDLE: begin
                if (eligible != '0) begin
                    code_d  = highest(eligible);
                    valid_d = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (ack) begin
                    clr     = {{(WIDTH-1){1'b0}}, 1'b1} << code_q;
                    valid_d = 1'b0;
                    state_d = CLEAR;
                end
            end
            // One bubble so the cleared pending vector is re-evaluated in IDLE.
            CLEAR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        pending_d = (pending_q & ~clr) | rise;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            req_q     <= '0;
            pending_q <= '0;
            mask_q    <= '1;
            code_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
        end
    end

`ifdef IRQ_PRIO_OVERFLOW_EN
    logic [WIDTH-1:0] overflow_q, overflow_d;

    assign overflow_d = overflow_q | (rise & pending_q & ~clr);

    always_ff @(posedge clk) begin
        if (rst) overflow_q <= '0;
        else     overflow_q <= overflow_d;
    end

    assign overflow = overflow_q;
`endif

    assign code    = code_q;
    assign valid   = valid_q;
    assign pending = pending_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_irq_prio_capture.sv
// Directed bench for irq_prio_capture: a cycle-level behavioural model checked every cycle plus literal checkpoints.
module tb_irq_prio_capture;

    localparam int WIDTH  = 4;
    localparam int CODE_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [WIDTH-1:0]  req;
    logic              mask_we;
    logic [WIDTH-1:0]  mask_wdata;
    logic              ack;
    logic [CODE_W-1:0] code;
    logic              valid;
    logic [WIDTH-1:0]  pending;
    logic              busy;
`ifdef IRQ_PRIO_OVERFLOW_EN
    logic [WIDTH-1:0]  overflow;
`endif

    irq_prio_capture #(.WIDTH(WIDTH), .CODE_W(CODE_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .ack        (ack),
        .code       (code),
        .valid      (valid),
        .pending    (pending),
`ifdef IRQ_PRIO_OVERFLOW_EN
        .overflow   (overflow),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pending as a bit set, a presented slot, and a gap counter
    // for the quiet cycles that must follow every acknowledgement.
    int m_pend, m_mask, m_prev, m_code, m_gap, m_ovf;
    bit m_valid;

    always @(posedge clk) begin
        int rise, clr, elig, win;
        if (rst) begin
            m_pend = 0; m_mask = 'hF; m_prev = 0; m_code = 0;
            m_gap = 0; m_valid = 0; m_ovf = 0;
        end else begin
            rise = int'(req) & ~m_prev & 'hF;
            clr  = (m_valid && ack) ? (1 << m_code) : 0;
            elig = m_pend & m_mask;
            m_ovf = m_ovf | (rise & m_pend & ~clr);
            if (m_valid) begin
                if (ack) begin
                    m_valid = 0;
                    m_gap   = 1;
                end
            end else if (m_gap > 0) begin
                m_gap = m_gap - 1;
            end else if (elig != 0) begin
                win = 0;
                for (int i = 0; i < WIDTH; i++) if ((elig >> i) & 1) win = i;
                m_code  = win;
                m_valid = 1;
            end
            m_pend = (m_pend & ~clr) | rise;
            if (mask_we) m_mask = int'(mask_wdata);
            m_prev = int'(req);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc.code",    int'(code),    m_code);
            chk("cyc.valid",   int'(valid),   int'(m_valid));
            chk("cyc.pending", int'(pending), m_pend);
            chk("cyc.busy",    int'(busy),    int'(m_valid || m_gap > 0));
`ifdef IRQ_PRIO_OVERFLOW_EN
            chk("cyc.overflow", int'(overflow), m_ovf);
`endif
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        while (!valid && k < 12) begin
            cyc(1);
            k++;
        end
        if (!valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: valid not seen within 12 cycles", name);
        end
    endtask

    task automatic do_ack();
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = '0; mask_we = 1'b0; mask_wdata = '0; ack = 1'b0;
        cyc(2);
        rst = 1'b0;
        chk_en = 1'b1;

        // Idle after reset
        cyc(10);
        chk("idle.valid", int'(valid), 0);
        chk("idle.code", int'(code), 0);
        chk("idle.pending", int'(pending), 0);
        chk("idle.busy", int'(busy), 0);

        // Two simultaneous rises, serviced highest first
        req = 4'b0110;
        cyc(1);
        chk("two.pend", int'(pending), 'h6);
        chk("two.valid_early", int'(valid), 0);
        cyc(1);
        chk("two.valid", int'(valid), 1);
        chk("two.code", int'(code), 2);
        do_ack();
        chk("two.pend_ack", int'(pending), 'h2);
        chk("two.busy_clear", int'(busy), 1);
        cyc(1);
        chk("two.gap_valid", int'(valid), 0);
        cyc(1);
        chk("two.valid2", int'(valid), 1);
        chk("two.code2", int'(code), 1);
        do_ack();
        chk("two.pend_empty", int'(pending), 0);
        req = '0;
        cyc(3);
        chk("two.idle", int'(busy), 0);

        // All four lines at once
        req = 4'b1111;
        cyc(1);
        chk("all.pend", int'(pending), 'hF);
        for (int k = 3; k >= 0; k--) begin
            wait_valid("all.wait");
            chk("all.code", int'(code), k);
            do_ack();
        end
        cyc(5);
        chk("all.done_valid", int'(valid), 0);
        chk("all.done_pend", int'(pending), 0);
        req = '0;
        cyc(1);

        // Masked request is recorded but not presented; stray ack ignored
        mask_we = 1'b1; mask_wdata = 4'b0111;
        cyc(1);
        mask_we = 1'b0;
        req = 4'b1000;
        cyc(1);
        req = '0;
        chk("mask.pend", int'(pending), 'h8);
        cyc(4);
        chk("mask.valid", int'(valid), 0);
        chk("mask.busy", int'(busy), 0);
        ack = 1'b1;
        cyc(2);
        ack = 1'b0;
        chk("mask.stray_ack", int'(pending), 'h8);
        mask_we = 1'b1; mask_wdata = 4'b1111;
        cyc(1);
        mask_we = 1'b0;
        cyc(1);
        chk("mask.valid_open", int'(valid), 1);
        chk("mask.code_open", int'(code), 3);
        do_ack();
        cyc(2);

        // Re-rise during the ack cycle keeps the bit pending
        req = 4'b0010;
        cyc(1);
        req = '0;
        wait_valid("rerise.wait");
        chk("rerise.code", int'(code), 1);
        ack = 1'b1; req = 4'b0010;
        cyc(1);
        ack = 1'b0; req = '0;
        chk("rerise.pend", int'(pending), 'h2);
        chk("rerise.valid_off", int'(valid), 0);
`ifdef IRQ_PRIO_OVERFLOW_EN
        chk("rerise.ovf_none", int'(overflow), 0);
`endif
        cyc(2);
        chk("rerise.valid_again", int'(valid), 1);
        chk("rerise.code_again", int'(code), 1);
        req = 4'b0010;
        cyc(1);
        req = '0;
`ifdef IRQ_PRIO_OVERFLOW_EN
        chk("rerise.ovf_set", int'(overflow), 'h2);
`endif
        chk("rerise.code_stable", int'(code), 1);
        do_ack();
        cyc(3);

        // Reset while presenting
        req = 4'b1010;
        cyc(1);
        req = '0;
        chk("rst.pend_pre", int'(pending), 'hA);
        mask_we = 1'b1; mask_wdata = 4'b0111;
        cyc(1);
        mask_we = 1'b0;
        chk("rst.valid_pre", int'(valid), 1);
        chk("rst.code_pre", int'(code), 3);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("rst.valid", int'(valid), 0);
        chk("rst.pend", int'(pending), 0);
        chk("rst.busy", int'(busy), 0);
        chk("rst.code", int'(code), 0);
`ifdef IRQ_PRIO_OVERFLOW_EN
        chk("rst.ovf", int'(overflow), 0);
`endif
        // Mask restored to all ones: bit 3 must be presented
        req = 4'b1000;
        cyc(1);
        req = '0;
        cyc(1);
        chk("rst.mask_restored_valid", int'(valid), 1);
        chk("rst.mask_restored_code", int'(code), 3);
        do_ack();
        cyc(3);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
